// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned TIMER_W = 16;

  // Requester-id width; never below one bit so a field always exists.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after the pointer, wrapping.
module rr_arbiter
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = id_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_k = IW'((32'(i_ptr) + 32'(i)) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid  = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx    = w_k;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shares one binary-to-BCD converter among NUM_REQ requesters with round-robin
// arbitration, start/done sequencing, id-tagged responses and a done watchdog.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BIN_W       = 16,
  parameter int unsigned BCD_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*BIN_W-1:0]   bin_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic                       resp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_o,
  output logic [BCD_W-1:0]           resp_bcd_o,
  output logic                       resp_err_o,
  output logic                       conv_start_o,
  output logic [BIN_W-1:0]           conv_bin_o,
  input  logic                       conv_ready_i,
  input  logic                       conv_done_i,
  input  logic [BCD_W-1:0]           conv_bcd_i
);

  localparam int unsigned ID_W = id_w(NUM_REQ);

  state_t             r_state,  w_state_nxt;
  logic [ID_W-1:0]    r_ptr,    w_ptr_nxt;
  logic [ID_W-1:0]    r_id,     w_id_nxt;
  logic [TIMER_W-1:0] r_timer,  w_timer_nxt;
  logic [NUM_REQ-1:0] r_ack,    w_ack_nxt;
  logic               r_start,  w_start_nxt;
  logic [BIN_W-1:0]   r_bin,    w_bin_nxt;
  logic               r_rvalid, w_rvalid_nxt;
  logic [ID_W-1:0]    r_rid,    w_rid_nxt;
  logic [BCD_W-1:0]   r_rbcd,   w_rbcd_nxt;
  logic               r_rerr,   w_rerr_nxt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_gnt_valid;
  logic [TIMER_W-1:0] w_timer_inc;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign w_timer_inc = r_timer + TIMER_W'(1);

  // State and all output-facing registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_timer  <= '0;
      r_ack    <= '0;
      r_start  <= 1'b0;
      r_bin    <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rbcd   <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_id     <= w_id_nxt;
      r_timer  <= w_timer_nxt;
      r_ack    <= w_ack_nxt;
      r_start  <= w_start_nxt;
      r_bin    <= w_bin_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rid    <= w_rid_nxt;
      r_rbcd   <= w_rbcd_nxt;
      r_rerr   <= w_rerr_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_id_nxt     = r_id;
    w_timer_nxt  = r_timer;
    w_ack_nxt    = '0;
    w_start_nxt  = 1'b0;
    w_bin_nxt    = r_bin;
    w_rvalid_nxt = 1'b0;
    w_rid_nxt    = r_rid;
    w_rbcd_nxt   = r_rbcd;
    w_rerr_nxt   = r_rerr;

    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid && conv_ready_i) begin
          w_state_nxt = START;
          w_id_nxt    = w_gnt_idx;
          w_bin_nxt   = bin_i[32'(w_gnt_idx)*BIN_W +: BIN_W];
          w_ack_nxt   = w_gnt;
          w_start_nxt = 1'b1;
        end
      end
      START: begin
        w_ptr_nxt   = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
        w_timer_nxt = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_timer_nxt = w_timer_inc;
        // Done takes priority over a coincident timeout.
        if (conv_done_i) begin
          w_rbcd_nxt   = conv_bcd_i;
          w_rerr_nxt   = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_rid_nxt    = r_id;
          w_state_nxt  = RESP;
        end else if (w_timer_inc == TIMER_W'(TIMEOUT_CYC)) begin
          w_rbcd_nxt   = '0;
          w_rerr_nxt   = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_rid_nxt    = r_id;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign ack_o        = r_ack;
  assign conv_start_o = r_start;
  assign conv_bin_o   = r_bin;
  assign resp_valid_o = r_rvalid;
  assign resp_id_o    = r_rid;
  assign resp_bcd_o   = r_rbcd;
  assign resp_err_o   = r_rerr;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed bench for bcd_convert_scheduler with a behavioural converter model.
module tb_bcd_convert_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned BW   = 16;
  localparam int unsigned CW   = 20;
  localparam int unsigned TO   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*BW-1:0] bin;
  logic [NREQ-1:0]   ack;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [CW-1:0]     resp_bcd;
  logic              resp_err;
  logic              conv_start;
  logic [BW-1:0]     conv_bin;
  logic              conv_ready;
  logic              conv_done;
  logic [CW-1:0]     conv_bcd;

  always #5 clk = ~clk;

  bcd_convert_scheduler #(
    .NUM_REQ(NREQ), .BIN_W(BW), .BCD_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req),
    .bin_i        (bin),
    .ack_o        (ack),
    .resp_valid_o (resp_valid),
    .resp_id_o    (resp_id),
    .resp_bcd_o   (resp_bcd),
    .resp_err_o   (resp_err),
    .conv_start_o (conv_start),
    .conv_bin_o   (conv_bin),
    .conv_ready_i (conv_ready),
    .conv_done_i  (conv_done),
    .conv_bcd_i   (conv_bcd)
  );

  // Converter model: busy for m_lat+1 edges after start, then a done pulse (unless stubbed).
  logic          m_busy = 1'b0;
  int            m_cnt  = 0;
  logic [BW-1:0] m_bin  = '0;
  logic          m_done = 1'b0;
  logic [CW-1:0] m_bcd  = '0;
  int            m_lat  = 2;
  logic          stub   = 1'b0;
  logic          hold_nr = 1'b0;

  function automatic logic [CW-1:0] to_bcd(input logic [BW-1:0] b);
    int v;
    logic [CW-1:0] r;
    v = int'(b);
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (conv_start && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      m_bin  <= conv_bin;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        if (!stub) begin
          m_done <= 1'b1;
          m_bcd  <= to_bcd(m_bin);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign conv_ready = !m_busy && !hold_nr;
  assign conv_done  = m_done;
  assign conv_bcd   = m_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_bin(input int k, input logic [BW-1:0] v);
    bin[k*BW +: BW] = v;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ack"},        32'(ack),        32'h0);
    check({tag, " start"},      32'(conv_start), 32'h0);
    check({tag, " conv_bin"},   32'(conv_bin),   32'h0);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, " resp_id"},    32'(resp_id),    32'h0);
    check({tag, " resp_bcd"},   32'(resp_bcd),   32'h0);
    check({tag, " resp_err"},   32'(resp_err),   32'h0);
  endtask

  // Transaction log filled by run_seq.
  int            n_ack, n_rsp;
  logic [3:0]    g_ack[8];
  logic          g_ack_start[8];
  int            g_ack_cyc[8];
  logic [1:0]    g_id[8];
  logic [CW-1:0] g_bcd[8];
  logic          g_err[8];
  int            g_rsp_cyc[8];

  // Raise mask, drop each bit on its ack unless hold, until n responses or budget.
  task automatic run_seq(input logic [3:0] mask, input bit hold, input int n);
    int cyc;
    n_ack = 0;
    n_rsp = 0;
    cyc   = 0;
    @(negedge clk);
    req = mask;
    while (n_rsp < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ack != '0 && n_ack < 8) begin
        g_ack[n_ack]       = ack;
        g_ack_start[n_ack] = conv_start;
        g_ack_cyc[n_ack]   = cyc;
        n_ack++;
        if (!hold) req = req & ~ack;
      end
      if (resp_valid && n_rsp < 8) begin
        g_id[n_rsp]      = resp_id;
        g_bcd[n_rsp]     = resp_bcd;
        g_err[n_rsp]     = resp_err;
        g_rsp_cyc[n_rsp] = cyc;
        n_rsp++;
      end
    end
    req = '0;
    if (n_rsp < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_seq timeout: got %0d responses expected %0d", n_rsp, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int            id;
    logic [BW-1:0] bin;
    logic [CW-1:0] bcd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit found;
    vecs[0] = '{0, 16'd1234,  20'h01234};
    vecs[1] = '{1, 16'd0,     20'h00000};
    vecs[2] = '{2, 16'd9,     20'h00009};
    vecs[3] = '{3, 16'd10,    20'h00010};
    vecs[4] = '{1, 16'd99,    20'h00099};
    vecs[5] = '{2, 16'd65535, 20'h65535};
    vecs[6] = '{0, 16'd100,   20'h00100};
    vecs[7] = '{3, 16'd50000, 20'h50000};

    reset = 1'b1;
    req   = '0;
    bin   = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Single-requester vectors, including test 1 as the first entry.
    for (int v = 0; v < 8; v++) begin
      set_bin(vecs[v].id, vecs[v].bin);
      run_seq(4'(1 << vecs[v].id), 1'b0, 1);
      check($sformatf("v%0d ack", v),       32'(g_ack[0]),       32'(1 << vecs[v].id));
      check($sformatf("v%0d ack_start", v), 32'(g_ack_start[0]), 32'h1);
      check($sformatf("v%0d ack_lat", v),   32'(g_ack_cyc[0]),   32'd1);
      check($sformatf("v%0d resp_lat", v),  32'(g_rsp_cyc[0] - g_ack_cyc[0]), 32'd5);
      check($sformatf("v%0d id", v),        32'(g_id[0]),        32'(vecs[v].id));
      check($sformatf("v%0d bcd", v),       32'(g_bcd[0]),       32'(vecs[v].bcd));
      check($sformatf("v%0d err", v),       32'(g_err[0]),       32'h0);
      @(negedge clk);
      check($sformatf("v%0d valid_pulse", v), 32'(resp_valid), 32'h0);
      check($sformatf("v%0d bcd_hold", v),    32'(resp_bcd),   32'(vecs[v].bcd));
    end

    // All four requesting from a fresh pointer: served in id order.
    do_reset();
    set_bin(0, 16'd1);
    set_bin(1, 16'd22);
    set_bin(2, 16'd333);
    set_bin(3, 16'd4444);
    run_seq(4'b1111, 1'b0, 4);
    check("multi n_ack", 32'(n_ack), 32'd4);
    check("multi id0",  32'(g_id[0]),  32'd0);
    check("multi id1",  32'(g_id[1]),  32'd1);
    check("multi id2",  32'(g_id[2]),  32'd2);
    check("multi id3",  32'(g_id[3]),  32'd3);
    check("multi ack0", 32'(g_ack[0]), 32'b0001);
    check("multi ack3", 32'(g_ack[3]), 32'b1000);
    check("multi bcd0", 32'(g_bcd[0]), 32'h00001);
    check("multi bcd1", 32'(g_bcd[1]), 32'h00022);
    check("multi bcd2", 32'(g_bcd[2]), 32'h00333);
    check("multi bcd3", 32'(g_bcd[3]), 32'h04444);

    // Fairness with two requesters held continuously.
    set_bin(0, 16'd7);
    set_bin(3, 16'd8000);
    run_seq(4'b1001, 1'b1, 4);
    check("fair id0",  32'(g_id[0]),  32'd0);
    check("fair id1",  32'(g_id[1]),  32'd3);
    check("fair id2",  32'(g_id[2]),  32'd0);
    check("fair id3",  32'(g_id[3]),  32'd3);
    check("fair bcd1", 32'(g_bcd[1]), 32'h08000);
    check("fair bcd2", 32'(g_bcd[2]), 32'h00007);

    // Converter never finishes: timeout response after 10 WAIT cycles.
    stub = 1'b1;
    set_bin(2, 16'd77);
    run_seq(4'b0100, 1'b0, 1);
    stub = 1'b0;
    check("tmo id",    32'(g_id[0]),  32'd2);
    check("tmo err",   32'(g_err[0]), 32'h1);
    check("tmo bcd",   32'(g_bcd[0]), 32'h0);
    check("tmo delay", 32'(g_rsp_cyc[0] - g_ack_cyc[0]), 32'd11);

    set_bin(1, 16'd4321);
    run_seq(4'b0010, 1'b0, 1);
    check("post_tmo id",  32'(g_id[0]),  32'd1);
    check("post_tmo err", 32'(g_err[0]), 32'h0);
    check("post_tmo bcd", 32'(g_bcd[0]), 32'h04321);

    // Done in the last WAIT cycle beats the timeout.
    m_lat = 8;
    set_bin(0, 16'd2468);
    run_seq(4'b0001, 1'b0, 1);
    check("edge_done err",   32'(g_err[0]), 32'h0);
    check("edge_done bcd",   32'(g_bcd[0]), 32'h02468);
    check("edge_done delay", 32'(g_rsp_cyc[0] - g_ack_cyc[0]), 32'd11);

    // Done one cycle too late: timeout, and the late done is ignored.
    m_lat = 9;
    set_bin(3, 16'd1357);
    run_seq(4'b1000, 1'b0, 1);
    check("late_done err", 32'(g_err[0]), 32'h1);
    check("late_done bcd", 32'(g_bcd[0]), 32'h0);
    m_lat = 2;
    run_seq(4'b0000, 1'b0, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("late_done no_resp", 32'(cnt), 32'd0);

    // Reset in WAIT: outputs clear and the converter's late done is ignored.
    set_bin(0, 16'd555);
    @(negedge clk);
    req = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ack != '0) found = 1'b1;
    end
    check("rst_wait ack_seen", 32'(found), 32'h1);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_wait");
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("rst_wait no_resp", 32'(cnt), 32'd0);
    set_bin(3, 16'd65535);
    run_seq(4'b1000, 1'b0, 1);
    check("rst_after id",  32'(g_id[0]),  32'd3);
    check("rst_after bcd", 32'(g_bcd[0]), 32'h65535);
    check("rst_after err", 32'(g_err[0]), 32'h0);

    // Converter not ready: request waits, start follows ready by one cycle.
    hold_nr = 1'b1;
    set_bin(1, 16'd808);
    @(negedge clk);
    req = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack != '0 || conv_start) cnt++;
    end
    check("notready no_start", 32'(cnt), 32'd0);
    hold_nr = 1'b0;
    @(negedge clk);
    check("ready start", 32'(conv_start), 32'h1);
    check("ready ack",   32'(ack),        32'b0010);
    check("ready bin",   32'(conv_bin),   32'd808);
    req = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        found = 1'b1;
        check("ready bcd", 32'(resp_bcd), 32'h00808);
        check("ready id",  32'(resp_id),  32'd1);
      end
    end
    check("ready resp_seen", 32'(found), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
